muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  issue a multiply/divide op from decode
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  rs operand
- b  in  32  rt operand
- mf_req  in  1  decode holds MFHI/MFLO
- mf_sel  in  1  0 LO, 1 HI
- mt_we  in  1  MTHI/MTLO write
- mt_sel  in  1  0 LO, 1 HI
- mt_data  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, HI/LO just updated
- hold_pc  out  1  freeze PC
- hold_if  out  1  freeze IF/ID register
- mf_data  out  32  selected HI or LO value
- div0  out  1  divide-by-zero pulse (MULDIV_DIV0_EXC_EN only)

Function
REQ-003 SHALL implement states IDLE, PREP, RUN, FIX; reset state IDLE.
REQ-004 IDLE: start=1 at edge E0 SHALL latch op, a and b, and move to PREP; otherwise SHALL stay in IDLE.
REQ-005 PREP (1 cycle): for signed ops, SHALL take the absolute values of the operands and record the result sign and remainder sign; SHALL load the 5-bit iteration counter with 31.
REQ-006 RUN SHALL last exactly 32 cycles, one iteration per cycle:
- multiply: shift-add on a 64-bit accumulator
- divide: restoring divide, one quotient bit per cycle
- RUN exits to FIX when the counter is 0; the counter wraps to 31 only on PREP entry.
REQ-007 FIX (1 cycle) SHALL negate the results as required and write HI/LO at the edge that leaves FIX; state becomes IDLE.
REQ-008 Write-back values:
- multiply: HI = product[63:32], LO = product[31:0]
- divide: LO = quotient, HI = remainder
- the signed remainder takes the sign of the dividend.
REQ-009 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0, with no flag.
REQ-010 Timing: busy=1 from edge E0 to edge E0+34; done=1 for the single cycle following edge E0+34; busy=0 in that cycle.
REQ-011 start while busy=1 SHALL be ignored: no state change, operands not relatched.
REQ-012 mt_we in IDLE SHALL write mt_data to HI or LO at the edge; mt_we while busy=1 SHALL be ignored.
REQ-013 start and mt_we in the same IDLE cycle: start SHALL be taken and mt_we dropped.
REQ-014 mf_data SHALL be combinational from the HI/LO registers.
- mf_req with mt_we on the same register returns the pre-write value.
- In the done cycle it returns the new result.
REQ-015 hold_pc = hold_if = mf_req & busy, combinational; both SHALL be 0 whenever busy=0.
REQ-016 A MULT/DIV back-to-back issue with start=1 in the done cycle SHALL be accepted; the done cycle is IDLE.

Reset
REQ-017 rst=1 SHALL force, asynchronously and including mid-operation:
- state IDLE, counter 0
- HI=0, LO=0, accumulators 0
- busy=0, done=0, div0=0, hold_pc=0, hold_if=0.
REQ-018 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-019 Macro MULDIV_DIV0_EXC_EN defined:
- DIV/DIVU with b=0 SHALL go IDLE->IDLE with HI/LO unchanged.
- div0=1 for one cycle after the edge; busy stays 0.
REQ-020 MULDIV_DIV0_EXC_EN undefined:
- the div0 port SHALL be absent.
- divide by zero SHALL run the normal 34-cycle sequence and give DIVU LO=0xFFFFFFFF, HI=a.
- signed DIV by zero SHALL give HI/LO equal to the restoring algorithm's output after sign fix-up.

Verification
REQ-021 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 34 cycles after the start edge, HI=0xFFFFFFFE, LO=0x00000001.
REQ-022 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); MULT a=-3, b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-023 Start DIVU 100/7, then assert mf_req (mf_sel=0) at cycle 5 -> hold_pc/hold_if high until the done cycle; mf_data=14 in the done cycle; hold low after it.
REQ-024 mt_we LO=0x1234 in IDLE, then start with mt_we HI=0x5678 in the same cycle -> LO=0x1234, HI unchanged until the op result overwrites it.
REQ-025 rst pulsed at RUN cycle 10 -> busy=0, HI=LO=0, no done pulse; next MULTU 3x4 -> LO=12, HI=0.
REQ-026 DIVU 5/0 -> with MULDIV_DIV0_EXC_EN: div0 pulse, HI/LO unchanged, busy never 1; without it: LO=0xFFFFFFFF, HI=5 after 34 cycles.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_DIV0_EXC_EN: divide-by-zero is trapped in IDLE and reported on div0.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mf_req,
    input  logic        mf_sel,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic        hold_pc,
    output logic        hold_if,
`ifdef MULDIV_DIV0_EXC_EN
    output logic        div0,
`endif
    output logic [31:0] mf_data
);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_qneg;
    logic        r_rneg;
    logic        r_done;

    logic        w_div0_trap;
    logic        w_accept;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_mul_sum;
    logic [32:0] w_rem_sh;
    logic        w_rem_ge;
    logic [31:0] w_rem_sub;
    logic [63:0] w_step;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

`ifdef MULDIV_DIV0_EXC_EN
    logic        r_div0;

    assign w_div0_trap = start && op[1] && (b == 32'd0);
    assign div0        = r_div0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_div0 <= 1'b0;
        else
            r_div0 <= (r_state == IDLE) && w_div0_trap;
    end
`else
    assign w_div0_trap = 1'b0;
`endif

    assign w_accept = start && !w_div0_trap;

    // Operand conditioning: signed ops work on magnitudes, signs are reapplied in FIX.
    assign w_signed = ~r_op[0];
    assign w_a_neg  = w_signed & r_a[31];
    assign w_b_neg  = w_signed & r_b[31];
    assign w_a_abs  = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_abs  = w_b_neg ? (32'd0 - r_b) : r_b;

    // r_acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b : 32'd0)};
    assign w_rem_sh  = {r_acc[63:32], r_acc[31]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh[31:0] - r_b;
    assign w_step    = r_op[1]
                     ? (w_rem_ge ? {w_rem_sub, r_acc[30:0], 1'b1}
                                 : {w_rem_sh[31:0], r_acc[30:0], 1'b0})
                     : {w_mul_sum, r_acc[31:1]};

    assign w_prod_fix = r_qneg ? (64'd0 - r_acc) : r_acc;
    assign w_quo_fix  = r_qneg ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem_fix  = r_rneg ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept)
                    w_state_next = PREP;
            end
            PREP: w_state_next = RUN;
            RUN:  if (r_cnt == 5'd0) w_state_next = FIX;
            FIX:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= 2'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_acc  <= 64'd0;
            r_cnt  <= 5'd0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // start wins over a same-cycle MTHI/MTLO, including a trapped divide.
                    if (w_accept) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                    end else if (mt_we && !start) begin
                        if (mt_sel)
                            r_hi <= mt_data;
                        else
                            r_lo <= mt_data;
                    end
                end
                PREP: begin
                    r_acc  <= {32'd0, w_a_abs};
                    r_b    <= w_b_abs;
                    r_qneg <= w_a_neg ^ w_b_neg;
                    r_rneg <= w_a_neg;
                    r_cnt  <= 5'd31;
                end
                RUN: begin
                    r_acc <= w_step;
                    if (r_cnt != 5'd0)
                        r_cnt <= r_cnt - 5'd1;
                end
                FIX: begin
                    if (r_op[1]) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done    = r_done;
    assign hold_pc = mf_req & busy;
    assign hold_if = mf_req & busy;
    assign mf_data = mf_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO, a monitor checks each done pulse.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mf_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic        mt_we = 1'b0;
    logic        mt_sel = 1'b0;
    logic [31:0] mt_data = 32'd0;
    logic        busy;
    logic        done;
    logic        hold_pc;
    logic        hold_if;
    logic [31:0] mf_data;
`ifdef MULDIV_DIV0_EXC_EN
    logic        div0;
`endif

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mf_req(mf_req), .mf_sel(mf_sel), .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .busy(busy), .done(done), .hold_pc(hold_pc), .hold_if(hold_if),
`ifdef MULDIV_DIV0_EXC_EN
        .div0(div0),
`endif
        .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          dcyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %08h want %08h (cyc %0d)", name, got, want, cyc);
    endtask

    // Reference: plain integer arithmetic; zero divisor follows the restoring-divide outcome.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] res;
        sx = $signed(x);
        sy = $signed(y);
        res = 64'd0;
        case (o)
            2'd0: res = sx * sy;
            2'd1: res = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0)
                    res = {x, (x[31] ? 32'd1 : 32'hFFFFFFFF)};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0)
                    res = {x, 32'hFFFFFFFF};
                else
                    res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one done pulse per queued op, exactly 34 cycles after its start edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                if (sb_q.size() == 0)
                    chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.dcyc);
                    chk("busy_in_done", 32'(busy), 32'd0);
                    mf_sel = 1'b0;
                    #1 chk("result_lo", mf_data, e.lo);
                    mf_sel = 1'b1;
                    #1 chk("result_hi", mf_data, e.hi);
                    mf_sel = 1'b0;
                    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h @cyc %0d",
                             e.op, e.a, e.b, e.hi, e.lo, cyc);
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].dcyc) begin
                chk("missing_done", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic mtw, input logic mts, input logic [31:0] mtd, output int e0);
        logic [63:0] r;
        exp_t        e;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        mt_we = mtw; mt_sel = mts; mt_data = mtd;
        @(posedge clk);
        #1;
        start = 1'b0;
        mt_we = 1'b0;
        e0 = cyc;
`ifdef MULDIV_DIV0_EXC_EN
        if (o[1] && y == 32'd0) begin
            chk("div0_pulse", 32'(div0), 32'd1);
            chk("div0_busy", 32'(busy), 32'd0);
            return;
        end
`endif
        r = ref_model(o, x, y);
        e.op = o; e.a = x; e.b = y;
        e.hi = r[63:32]; e.lo = r[31:0]; e.dcyc = e0 + 34;
        sb_q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
    endtask

    task automatic read_hl(input string name, input logic [31:0] want_hi, input logic [31:0] want_lo);
        mf_sel = 1'b0;
        #1 chk({name, "_lo"}, mf_data, want_lo);
        mf_sel = 1'b1;
        #1 chk({name, "_hi"}, mf_data, want_hi);
        mf_sel = 1'b0;
    endtask

    task automatic mt_write(input logic sel, input logic [31:0] d);
        @(negedge clk);
        mt_we = 1'b1; mt_sel = sel; mt_data = d;
        mf_req = 1'b1; mf_sel = sel;
        #1 chk("mf_prewrite", mf_data, sel ? m_hi : m_lo);
        @(posedge clk);
        #1;
        mt_we = 1'b0;
        mf_req = 1'b0;
        mf_sel = 1'b0;
        if (sel) m_hi = d; else m_lo = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cyc %0d want < 50000", cyc);
        $fatal(1);
    end

    initial begin
        int          e0;
        int          k;
        int          ndone;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] pre_hi;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hold_pc", 32'(hold_pc), 32'd0);
        chk("rst_hold_if", 32'(hold_if), 32'd0);
        read_hl("rst", 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed results; first start right after reset release
        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, e0);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_until(e0 + 33);
        chk("busy_last_fix", 32'(busy), 32'd1);
        wait_drain();
        issue(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'd0, e0);
        wait_drain();
        issue(2'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 32'd0, e0);
        wait_until(e0 + 33);
        issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, e0);
        wait_drain();
        issue(2'd3, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, e0);
        wait_drain();
        issue(2'd2, 32'hFFFFFFF7, 32'd0, 1'b0, 1'b0, 32'd0, e0);
        wait_drain();

        // Pipeline hold while MFLO waits on a divide
        issue(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, e0);
        wait_until(e0 + 5);
        mf_req = 1'b1;
        #1;
        while (cyc < e0 + 34) begin
            chk("hold_pc_busy", 32'(hold_pc), 32'd1);
            chk("hold_if_busy", 32'(hold_if), 32'd1);
            @(negedge clk);
            #1;
        end
        chk("hold_pc_done", 32'(hold_pc), 32'd0);
        chk("hold_if_done", 32'(hold_if), 32'd0);
        chk("mf_done_lo", mf_data, 32'd14);
        mf_req = 1'b0;
        wait_drain();

        // MTLO in idle, then start with a same-cycle MTHI, then MTLO while busy
        mt_write(1'b0, 32'h00001234);
        read_hl("mt_idle", m_hi, 32'h00001234);
        pre_hi = m_hi;
        issue(2'd1, 32'd6, 32'd7, 1'b1, 1'b1, 32'h00005678, e0);
        @(negedge clk);
        mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'hDEADBEEF;
        @(negedge clk);
        mt_we = 1'b0;
        read_hl("mt_busy", pre_hi, 32'h00001234);
        wait_drain();

        // Asynchronous reset in the middle of RUN
        issue(2'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'd0, e0);
        wait_until(e0 + 12);
        #2 rst = 1'b1;
        sb_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        read_hl("midrst", 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_done_after_rst", ndone, 32'd0);
        issue(2'd1, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, e0);
        wait_drain();

        // Random ops with ignored start/mt_we while busy and random back-to-back issue
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            issue(o, x, y, 1'b0, 1'b0, 32'd0, e0);
            k = $urandom_range(e0 + 1, e0 + 30);
            wait_until(k);
            start = 1'b1; op = ~o; a = $urandom; b = $urandom;
            mt_we = 1'b1; mt_sel = 1'($urandom_range(0, 1)); mt_data = $urandom;
            @(negedge clk);
            start = 1'b0;
            mt_we = 1'b0;
            if ($urandom_range(0, 1) == 1)
                wait_until(e0 + 33);
            else begin
                wait_drain();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
